tone_i2s_player: RTL and testbench
==================================

# tone_i2s_player

Downstream audio stage for the song tables: consumes the 32-bit `tone` frequency word (Hz; 100000000 means rest) and turns it into a square-wave PCM sample. That sample is serialized to the on-board I2S DAC (Pmod I2S) on the same clock. It holds all sequential audio timing: the DDS-style half-period generator, the frame divider and the I2S shifter. The song tables stay purely combinational.

## Interface
- `CLK_HZ`, 100000000, system clock frequency in Hz.
- `MAX_TONE`, 20000, highest audible tone; any tone above this, or tone 0, is silence.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous and active-low.
- `tone` in 32: requested frequency in Hz from the song table; may change on any cycle.
- `volume` in 3: amplitude select; values 0..6 are used, 7 saturates to 6.
- `audio_mclk` out 1: DAC master clock, clk/4.
- `audio_lrck` out 1: word select, clk/512; low = left, high = right.
- `audio_sck` out 1: serial bit clock, clk/8.
- `audio_sdin` out 1: serial data, MSB first, I2S one-bit delay.

## Operation
- Frame divider: 9-bit `cnt` is free-running and wraps 511→0.
  - `audio_mclk` = cnt[1].
  - `audio_sck` = cnt[2].
  - `audio_lrck` = cnt[8].
  - `slot` = cnt[7:3], giving 32 slots per channel half.
- Tone generator: 33-bit accumulator `acc` and a square `phase` bit.
  - Each cycle, `acc_n` = acc + 2·tone.
  - If acc_n ≥ CLK_HZ: acc ← acc_n − CLK_HZ and phase toggles. Otherwise acc ← acc_n.
  - With tone ≤ MAX_TONE, acc stays below CLK_HZ + 2·MAX_TONE, so 33 bits never overflow.
- Silence: tone == 0 or tone > MAX_TONE.
  - acc ← 0 and phase ← 0 that cycle.
  - The sample is 0.
- Amplitude: amp = 16'h0100 << min(volume, 6). This gives 0x0100..0x4000.
- Sample, 16-bit two's complement:
  - silence → 0.
  - phase=1 → +amp.
  - phase=0 → −amp.
- Tone change while audible: acc and phase are kept, so there is no click reset. The new increment applies from the next cycle.
- Frame latch: when cnt == 511, `held` ← current sample. The held sample is sent in both the left and right halves of the following frame.
- Serializer: in each half, slot 1..16 carry held[16−slot] (slot 1 = bit 15). Slots 0 and 17..31 carry 0.
- `audio_sdin` is registered and computed from the current cnt.

## Timing
- Reset values: cnt=0, acc=0, phase=0, held=0, and all four audio outputs 0.
  - Outputs stay 0 while rst_n is low.
  - The first lrck rise is 256 cycles after release.
- Release: counting starts on the first clk edge with rst_n high.
- Reset mid-frame: everything returns to reset values immediately (asynchronously). The partial frame is dropped, with no glitch beyond returning to 0.
- sdin timing:
  - sdin for a slot changes 1 cycle after that slot's sck falling edge (cnt[2:0]=0 → valid by cnt[2:0]=1).
  - It is stable through the sck rising edge at cnt[2:0]=4.
- Tone-to-DAC latency: a tone change reaches the sample at the next edge. It is serialized in the frame after the next cnt==511, so at most 512 + 17·8 cycles.
- Volume is sampled combinationally into the sample. It takes effect only through the frame latch, so there is no mid-word change.
- Square half-period: average CLK_HZ/(2·tone) cycles, with ±1 cycle jitter from the accumulator remainder.
- Simultaneous events:
  - Silence asserted on the same cycle as a toggle: silence wins, and phase = 0.
  - cnt==511 on the same cycle as a phase toggle: held takes the pre-toggle sample, i.e. the registered phase.

## Test plan
- Reset: hold rst_n low for 20 cycles with tone=440 → all outputs 0. After release, lrck rises at cycle 256, the sck period is 8 and the mclk period is 4.
- Frequency: tone=440, volume=2, run 10 ms → 8–9 phase toggles. Measured half-periods are 113636 or 113637 cycles.
- Serialization: force phase=1, volume=2 → both halves carry 0x0400 in slots 1..16 (MSB in slot 1) and zeros elsewhere. Check that each bit is stable at every sck rise.
- Silence: tone=100000000 → acc=0, phase=0, and sdin stays 0 for the whole frame. Switching to tone=262 makes audio resume within one frame after the first toggle.
- Volume saturation: volume=7 with phase=0 → word 0xC000 (−0x4000). With volume=0 → 0xFF00.
- Async reset mid-frame: pulse rst_n low at cnt=300 with the tone audible → outputs drop to 0 without waiting for clk. After release, framing restarts from cnt=0 and the first frame carries 0.

Source files
------------

// File: rtl/tone_i2s_player.sv
// -----------------------------------------------------------------------------
// tone_i2s_player
//
// Turns the song-table frequency word into a square-wave PCM sample and
// streams it to a Pmod I2S DAC. All audio timing lives here: the
// accumulator-based half-period generator, the 512-cycle frame divider and
// the I2S serializer. Each frame carries one held sample in both channels.
//
// Parameters
//   CLK_HZ    system clock frequency in Hz
//   MAX_TONE  highest audible tone in Hz; tone 0 or anything above is silence
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tone        requested frequency in Hz (may change on any cycle)
//   volume      amplitude select 0..6, 7 behaves as 6
//   audio_mclk  DAC master clock, clk/4
//   audio_lrck  word select, clk/512 (low = left, high = right)
//   audio_sck   serial bit clock, clk/8
//   audio_sdin  serial data, MSB first, one-bit I2S delay
// -----------------------------------------------------------------------------
module tone_i2s_player #(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned MAX_TONE = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tone,
  input  logic [2:0]  volume,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin
);

  localparam logic [32:0] CLK_HZ_W = 33'(CLK_HZ);

  // Frame divider: one full frame (left + right) every 512 cycles.
  logic [8:0]  cnt;
  logic [4:0]  slot;

  // Tone generator state.
  logic [32:0] acc;
  logic [32:0] acc_n;
  logic        phase;

  // Sample path.
  logic        silence;
  logic [2:0]  vol_sat;
  logic [15:0] amp;
  logic [15:0] sample;
  logic [15:0] held;
  logic        sdin_n;

  // The I2S clocks are plain register bits of the divider, so they are
  // glitch-free and sit at 0 whenever cnt is held in reset.
  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[2];
  assign audio_lrck = cnt[8];
  assign slot       = cnt[7:3];

  assign silence = (tone == 32'd0) || (tone > MAX_TONE);

  // Adding twice the tone per cycle and wrapping at CLK_HZ toggles phase
  // 2*tone times per second, i.e. a square wave at tone Hz. Audible tones
  // keep acc below CLK_HZ + 2*MAX_TONE, well inside 33 bits.
  assign acc_n = acc + {tone, 1'b0};

  // NOTE: every signal driven in always_comb gets a default assignment
  // first, so no path through the block leaves it unassigned (no latch).
  always_comb begin
    vol_sat = volume;
    if (volume == 3'd7) vol_sat = 3'd6;
    amp = 16'h0100 << vol_sat;

    sample = 16'd0;
    if (!silence) sample = phase ? amp : (16'd0 - amp);

    // Slots 1..16 carry the held word MSB first; slot 0 is the I2S
    // one-bit delay and slots 17..31 pad the 32-slot half with zeros.
    sdin_n = 1'b0;
    if ((slot >= 5'd1) && (slot <= 5'd16)) sdin_n = held[4'(5'd16 - slot)];
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // right-hand side sees the pre-edge value; held therefore captures the
  // sample built from the registered (pre-toggle) phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      acc        <= '0;
      phase      <= 1'b0;
      held       <= '0;
      audio_sdin <= 1'b0;
    end else begin
      cnt <= cnt + 9'd1;

      // Silence clears the generator so the next note starts from phase 0;
      // it overrides a toggle that would otherwise happen this cycle.
      if (silence) begin
        acc   <= '0;
        phase <= 1'b0;
      end else if (acc_n >= CLK_HZ_W) begin
        acc   <= acc_n - CLK_HZ_W;
        phase <= ~phase;
      end else begin
        acc <= acc_n;
      end

      // Latch once per frame so volume or phase changes never split a word.
      if (cnt == 9'd511) held <= sample;

      // Registered from the current slot: data moves one cycle after the
      // sck falling edge and is stable across the following rising edge.
      audio_sdin <= sdin_n;
    end
  end

endmodule

// File: tb/tb_tone_i2s_player.sv
// -----------------------------------------------------------------------------
// tb_tone_i2s_player
//
// Bench for tone_i2s_player. A behavioural model predicts the sample from
// the running sum of 2*tone since the last silence (phase = parity of
// sum / CLK_HZ) and the per-frame held word. Every completed channel half is
// decoded from sdin at the sck rising edges and compared with the model.
// A table of reset-to-frame vectors and hand-written sequences cover reset,
// framing, frequency, silence, volume saturation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_tone_i2s_player;

  localparam longint unsigned CLK_HZ   = 100000000;
  localparam logic [31:0]     MAX_TONE = 32'd20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tone = 32'd0;
  logic [2:0]  volume = 3'd0;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;

  tone_i2s_player dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tone       (tone),
    .volume     (volume),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------- model
  longint unsigned edges;     // clock edges since reset release
  longint unsigned total;     // sum of 2*tone since the last silent cycle
  logic [15:0]     m_held;    // word the DAC should receive this frame
  logic [31:0]     cap;       // slots decoded at sck rising edges
  logic [31:0]     last_word; // last completed half
  logic            cap_ref;
  bit              unstable;
  bit              clk_bad;

  function automatic logic [15:0] model_sample(input logic [31:0] t,
                                               input logic [2:0] v,
                                               input longint unsigned tot);
    logic [15:0] amp;
    int unsigned sh;
    if (t == 32'd0 || t > MAX_TONE) return 16'd0;
    sh  = (v > 3'd6) ? 6 : int'(v);
    amp = 16'h0100 << sh;
    if (((tot / CLK_HZ) % 2) == 1) return amp;
    return 16'd0 - amp;
  endfunction

  task automatic model_clear();
    edges    = 0;
    total    = 0;
    m_held   = 16'd0;
    cap      = 32'd0;
    cap_ref  = 1'b0;
    unstable = 0;
    clk_bad  = 0;
  endtask

  // One clock edge: advance the model with the inputs present before the
  // edge, then observe the DUT 1 time unit after it.
  task automatic tick();
    logic [15:0] s;
    int unsigned c;
    int unsigned sl;
    s = model_sample(tone, volume, total);
    if (edges % 512 == 511) m_held = s;
    if (tone == 32'd0 || tone > MAX_TONE) total = 0;
    else total = total + 64'(tone) * 2;

    @(posedge clk);
    #1;
    edges++;
    c  = 32'(edges % 512);
    sl = (c >> 3) & 31;

    if ({audio_lrck, audio_sck, audio_mclk} !==
        {c[8] == 1'b1, c[2] == 1'b1, c[1] == 1'b1}) clk_bad = 1;

    case (c & 7)
      1: cap_ref = audio_sdin;
      2, 3, 5, 6, 7: if (audio_sdin !== cap_ref) unstable = 1;
      4: begin
        if (audio_sdin !== cap_ref) unstable = 1;
        cap[31 - sl] = audio_sdin;
      end
      default: ;
    endcase

    if (c == 255 || c == 511) begin
      last_word = cap;
      check("word_vs_model", cap, {1'b0, m_held, 15'd0});
      check("sdin_stable", unstable, 0);
      check("clk_outputs", clk_bad, 0);
      cap      = 32'd0;
      unstable = 0;
      clk_bad  = 0;
    end
  endtask

  task automatic run_to(input longint unsigned target);
    while (edges < target) tick();
  endtask

  // Hold reset for n edges (asserting it now if not already low), then
  // release 1 unit after an edge so the next edge is the first counting one.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    model_clear();
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------- vectors
  typedef struct {
    logic [31:0] tone;
    logic [2:0]  vol;
    int          frame;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit          bad;
    longint unsigned t0, rise_sck0, rise_sck1, rise_mclk0, rise_mclk1;
    longint unsigned last_tog;
    logic        prev_phase, prev_sck, prev_mclk;
    int          ntog;
    bit          found;

    // frame k is the one after the k-th latch; frame 0 always carries 0
    vecs[0] = '{32'd440,       3'd2, 0,  16'h0000};
    vecs[1] = '{32'd440,       3'd2, 1,  16'hFC00};
    vecs[2] = '{32'd440,       3'd7, 1,  16'hC000};
    vecs[3] = '{32'd440,       3'd0, 1,  16'hFF00};
    vecs[4] = '{32'd100000000, 3'd3, 1,  16'h0000};
    vecs[5] = '{32'd0,         3'd5, 1,  16'h0000};
    vecs[6] = '{32'd20001,     3'd4, 1,  16'h0000};
    vecs[7] = '{32'd20000,     3'd1, 4,  16'hFE00};
    vecs[8] = '{32'd20000,     3'd2, 6,  16'h0400};
    // first toggle of 9766 Hz lands on the latch edge: pre-toggle phase wins
    vecs[9] = '{32'd9766,      3'd2, 10, 16'hFC00};

    model_clear();

    // ---- reset hold and release framing
    tone   = 32'd440;
    volume = 3'd2;
    rst_n  = 1'b0;
    bad    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({audio_mclk, audio_lrck, audio_sck, audio_sdin} !== 4'b0) bad = 1;
    end
    check("reset_outputs_low", bad, 0);
    @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;
    while (audio_lrck !== 1'b1 && edges < 600) tick();
    check("lrck_first_rise", edges, 256);

    rise_sck0 = 0; rise_sck1 = 0; rise_mclk0 = 0; rise_mclk1 = 0;
    prev_sck  = audio_sck;
    prev_mclk = audio_mclk;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (audio_sck && !prev_sck) begin
        if (rise_sck0 == 0) rise_sck0 = edges;
        else if (rise_sck1 == 0) rise_sck1 = edges;
      end
      if (audio_mclk && !prev_mclk) begin
        if (rise_mclk0 == 0) rise_mclk0 = edges;
        else if (rise_mclk1 == 0) rise_mclk1 = edges;
      end
      prev_sck  = audio_sck;
      prev_mclk = audio_mclk;
    end
    check("sck_period", rise_sck1 - rise_sck0, 8);
    check("mclk_period", rise_mclk1 - rise_mclk0, 4);

    // ---- table: reset, apply inputs, decode both halves of one frame
    for (int v = 0; v < 10; v++) begin
      tone   = vecs[v].tone;
      volume = vecs[v].vol;
      do_reset(3);
      run_to(64'(vecs[v].frame) * 512 + 255);
      check($sformatf("vec%0d_left", v), last_word, {1'b0, vecs[v].word, 15'd0});
      run_to(64'(vecs[v].frame) * 512 + 511);
      check($sformatf("vec%0d_right", v), last_word, {1'b0, vecs[v].word, 15'd0});
    end

    // ---- square half-period: exact for 20000 Hz, 2500/2501 for 19999 Hz
    tone   = 32'd20000;
    volume = 3'd2;
    do_reset(2);
    prev_phase = 1'b0;
    last_tog   = 0;
    ntog       = 0;
    while (edges < 10100) begin
      tick();
      if (dut.phase !== prev_phase) begin
        if (ntog == 0) check("first_toggle_20000", edges, 2500);
        else check("half_period_20000", edges - last_tog, 2500);
        ntog++;
        last_tog   = edges;
        prev_phase = dut.phase;
      end
    end
    check("toggles_20000", ntog, 4);

    tone = 32'd19999;
    do_reset(2);
    prev_phase = 1'b0;
    last_tog   = 0;
    ntog       = 0;
    while (edges < 10100) begin
      tick();
      if (dut.phase !== prev_phase) begin
        if (ntog == 0) check("first_toggle_19999", edges, 2501);
        else check("half_period_19999",
                   (edges - last_tog == 2500) || (edges - last_tog == 2501), 1);
        ntog++;
        last_tog   = edges;
        prev_phase = dut.phase;
      end
    end
    check("toggles_19999", ntog, 4);

    // ---- silence clears the generator, then audio resumes
    tone   = 32'd20000;
    volume = 3'd2;
    do_reset(2);
    run_to(3000);
    check("phase_before_silence", dut.phase, 1);
    tone = 32'd100000000;
    tick();
    check("silence_acc", dut.acc, 0);
    check("silence_phase", dut.phase, 0);
    run_to(3072 + 255);
    check("silent_frame_left", last_word, 0);
    run_to(3583);
    check("silent_frame_right", last_word, 0);
    tone  = 32'd20000;
    t0    = edges;
    found = 0;
    while (!found && edges - t0 < 512 + 17 * 8) begin
      tick();
      if (audio_sdin === 1'b1) found = 1;
    end
    check("resume_latency", found, 1);

    // ---- asynchronous reset in the middle of an audible frame
    tone   = 32'd440;
    volume = 3'd2;
    do_reset(2);
    run_to(812);
    check("pre_reset_lrck", audio_lrck, 1);
    check("pre_reset_sck", audio_sck, 1);
    check("pre_reset_sdin", audio_sdin, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {audio_mclk, audio_lrck, audio_sck, audio_sdin}, 4'b0000);
    do_reset(3);
    run_to(255);
    check("post_reset_left", last_word, 0);
    run_to(511);
    check("post_reset_right", last_word, 0);

    // ---- randomized inputs against the model
    volume = 3'd3;
    tone   = 32'd15000;
    do_reset(2);
    while (edges < 40 * 512) begin
      if ($urandom % 200 == 0) begin
        case ($urandom % 12)
          0:       tone = 32'd0;
          1:       tone = 32'd100000000;
          2:       tone = 32'd20001 + ($urandom % 1000);
          3:       tone = 32'd20000;
          default: tone = 32'd10000 + ($urandom % 10001);
        endcase
      end
      if ($urandom % 300 == 0) volume = 3'($urandom % 8);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
